// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NREQ byte
// requesters using round-robin grants and a done watchdog.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req_valid/data  per-requester byte offer (byte i at [8i+7:8i])
//   req_ready       one-hot accept pulse (transfer = valid & ready)
//   tx_start/byte   one-cycle start strobe and byte to transmitter
//   tx_active/done  transmitter status inputs
//   grant_id        index of last granted requester
//   busy            controller not in IDLE
//   timeout_err     sticky watchdog flag, cleared by err_clr

module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int TW             = 12,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST = GW'(NREQ - 1);

  state_e          state_q;
  logic [GW-1:0]   grant_id_q;
  logic [7:0]      tx_byte_q;
  logic            tx_start_q;
  logic            busy_q;
  logic            timeout_err_q;
  logic            done_q;
  logic [TW-1:0]   timer_q;

  logic            done_rise;
  logic            tx_idle;
  logic            any_hit;
  logic            grant_go;
  logic [GW-1:0]   pick_d;
  logic [GW-1:0]   cand;
  int              cand_int;

  assign done_rise = tx_done & ~done_q;
  assign tx_idle   = ~tx_active & ~tx_done;

  // Round-robin search starting one past the last grant.
  always_comb begin
    any_hit  = 1'b0;
    pick_d   = grant_id_q;
    cand_int = 0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_int = int'(grant_id_q) + i;
      if (cand_int >= NREQ) begin
        cand_int = cand_int - NREQ;
      end
      cand = GW'(cand_int);
      if (!any_hit && req_valid[cand]) begin
        any_hit = 1'b1;
        pick_d  = cand;
      end
    end
  end

  // Accept is combinational so the byte is taken in the IDLE
  // cycle and the start strobe follows one cycle later. Gating
  // with rst_n keeps ready low while reset is held.
  assign grant_go = rst_n && (state_q == IDLE) &&
                    any_hit && tx_idle;

  assign req_ready = grant_go ? (NREQ'(1) << pick_d) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_id_q    <= LAST;
      tx_byte_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
      timer_q       <= '0;
    end else begin
      done_q     <= tx_done;
      tx_start_q <= 1'b0;
      if (err_clr) begin
        timeout_err_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (grant_go) begin
            tx_byte_q  <= req_data[8*pick_d +: 8];
            grant_id_q <= pick_d;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
          if (done_rise) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timer_q == TMAX) begin
            // set beats a same-cycle err_clr
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter
// with a simple transmitter model.

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  // transmitter model controls
  logic hang = 1'b0;
  logic unhang = 1'b0;
  int   act_len = 10;
  int   done_len = 2;

  logic [3:0] exp_rr [5];
  logic [7:0] exp_b  [5];

  uart_tx_arbiter #(
    .NREQ(4),
    .TIMEOUT_CYCLES(16),
    .TW(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_byte(tx_byte),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ends 2 time units after the edge of the cycle with a grant
  task automatic wait_rr(input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rr"}, req_ready, 4'b0);
    chk({tag, "_start"}, tx_start, 1'b0);
    chk({tag, "_byte"}, tx_byte, 8'h00);
    chk({tag, "_gid"}, grant_id, 2'd3);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, timeout_err, 1'b0);
  endtask

  // transmitter: active for act_len cycles, then done for
  // done_len cycles; in hang mode active stays high until unhang
  initial begin
    int  m_act;
    int  m_done;
    logic m_hang;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        m_hang = hang;
        m_act  = act_len;
        m_done = done_len;
        @(posedge clk);
        #1;
        tx_active = 1'b1;
        if (m_hang) begin
          while (!unhang) begin
            @(posedge clk);
            #1;
          end
          tx_active = 1'b0;
        end else begin
          repeat (m_act) begin
            @(posedge clk);
            #1;
          end
          tx_active = 1'b0;
          tx_done   = 1'b1;
          repeat (m_done) begin
            @(posedge clk);
            #1;
          end
          tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = 32'h0;
    err_clr   = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single request from requester 0
    tick();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1;
    chk("t1_rr", req_ready, 4'b0001);
    chk("t1_start0", tx_start, 1'b0);
    tick();
    req_valid = 4'b0;
    #1;
    chk("t1_start", tx_start, 1'b1);
    chk("t1_byte", tx_byte, 8'hA5);
    chk("t1_gid", grant_id, 2'd0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_rr_off", req_ready, 4'b0);
    tick();
    #1;
    chk("t1_start_off", tx_start, 1'b0);
    chk("t1_byte_hold", tx_byte, 8'hA5);
    repeat (10) tick();
    #1;
    chk("t1_busy_rise", busy, 1'b1);
    tick();
    #1;
    chk("t1_busy_low", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // all four requesting: rotation 0,1,2,3,0
    req_data  = 32'h4332_2110;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_rr("t2_wait");
      chk("t2_rr", req_ready, exp_rr[i]);
      tick();
      if (i == 4) req_valid = 4'b0;
      #1;
      chk("t2_start", tx_start, 1'b1);
      chk("t2_byte", tx_byte, exp_b[i]);
      chk("t2_rr_pulse", req_ready, 4'b0);
    end

    // wrap: after grant 2, requesters 0 and 2 -> 0 then 2
    req_valid = 4'b0100;
    wait_rr("t3_wait_a");
    chk("t3_rr_a", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("t3_gid_a", grant_id, 2'd2);
    wait_rr("t3_wait_b");
    chk("t3_rr_b", req_ready, 4'b0001);
    tick();
    #1;
    chk("t3_gid_b", grant_id, 2'd0);
    chk("t3_byte_b", tx_byte, 8'h10);
    wait_rr("t3_wait_c");
    chk("t3_rr_c", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0;
    #1;
    chk("t3_gid_c", grant_id, 2'd2);
    chk("t3_byte_c", tx_byte, 8'h32);

    // done held 3 cycles: next start only after done falls
    done_len  = 3;
    req_valid = 4'b0010;
    wait_rr("t4_wait");
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        tick();
        if (k == 16) req_valid = 4'b0;
        #1;
      end
      chk("t4_rr", req_ready,
          (k == 0 || k == 15) ? 4'b0010 : 4'b0000);
      chk("t4_start", tx_start, 32'(k == 1 || k == 16));
    end
    chk("t4_gid", grant_id, 2'd1);

    // watchdog: transmitter never signals done
    tick();
    hang      = 1'b1;
    req_valid = 4'b1000;
    wait_rr("t5_wait");
    chk("t5_rr", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0;
    #1;
    chk("t5_start", tx_start, 1'b1);
    chk("t5_gid", grant_id, 2'd3);
    repeat (15) tick();
    tick();
    #1;
    chk("t5_err_pre", timeout_err, 1'b0);
    chk("t5_busy_pre", busy, 1'b1);
    tick();
    #1;
    chk("t5_err_set", timeout_err, 1'b1);
    chk("t5_busy_post", busy, 1'b0);
    tick();
    err_clr = 1'b1;
    #1;
    chk("t5_err_hold", timeout_err, 1'b1);
    tick();
    err_clr = 1'b0;
    #1;
    chk("t5_err_clr", timeout_err, 1'b0);
    unhang = 1'b1;
    tick();
    tick();
    unhang = 1'b0;

    // second timeout with err_clr on the set cycle
    req_valid = 4'b1000;
    wait_rr("t5b_wait");
    chk("t5b_rr", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0;
    #1;
    chk("t5b_start", tx_start, 1'b1);
    repeat (15) tick();
    tick();
    err_clr = 1'b1;
    #1;
    chk("t5b_err_pre", timeout_err, 1'b0);
    tick();
    err_clr = 1'b0;
    #1;
    chk("t5b_err_win", timeout_err, 1'b1);
    unhang = 1'b1;
    tick();
    tick();
    unhang = 1'b0;

    // reset in WAIT_DONE with transmitter active
    req_valid = 4'b0001;
    wait_rr("t6_wait");
    chk("t6_rr", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0;
    #1;
    chk("t6_start", tx_start, 1'b1);
    repeat (4) tick();
    req_valid = 4'b0011;
    rst_n     = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_rr_rel", req_ready, 4'b0);
    chk("t6_busy_rel", busy, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      #1;
      chk("t6_rr_blk", req_ready, 4'b0);
      chk("t6_start_blk", tx_start, 1'b0);
    end
    hang   = 1'b0;
    unhang = 1'b1;
    tick();
    #1;
    chk("t6_rr_go", req_ready, 4'b0001);
    tick();
    unhang    = 1'b0;
    req_valid = 4'b0;
    #1;
    chk("t6_start_go", tx_start, 1'b1);
    chk("t6_gid_go", grant_id, 2'd0);
    chk("t6_byte_go", tx_byte, 8'h10);
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
